// File: rtl/stim_replay_ctrl.sv
// Purpose : replays a table of {rpt, opcode} words onto the b12 inputs (__obs, k, start).
// Latency : entry 0 appears two cycles after the run edge; later entries follow with no gap.
// Backpr. : none; table writes are dropped while busy, run is ignored while busy.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data table write port, wr_data = {rpt, opcode[5:0]}
//   len, run, stop        replay length (sampled on run), start pulse, abort
//   busy, done            replay in progress / completed normally
//   obs, k, start         b12 stimulus (opcode[5], opcode[4:1], opcode[0])
//   pc, cyc_count         current entry index, DRIVE cycles since last run
module stim_replay_ctrl #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024,
  parameter int RPTW  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [6+RPTW-1:0] wr_data,
  input  logic [AW:0]       len,
  input  logic              run,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              obs,
  output logic [3:0]        k,
  output logic              start,
  output logic [AW-1:0]     pc,
  output logic [31:0]       cyc_count
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_DRIVE, S_DONE} state_t;

  localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];
  localparam logic [AW:0]   LEN_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PC_ONE  = {{(AW-1){1'b0}}, 1'b1};

  // Opcode table; not reset so contents survive reset and aborts.
  logic [6+RPTW-1:0] tbl_mem [DEPTH];
  logic [6+RPTW-1:0] rd_q;
  logic              rd_en;
  logic [AW-1:0]     rd_addr_d;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              drv_q, drv_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [AW:0]       len_q, len_d;
  logic [RPTW-1:0]   cnt_q, cnt_d;
  logic              first_q, first_d;

  logic [RPTW-1:0]   eff_cnt;
  logic              ent_last;
  logic              last_ent;

  // rd_q only changes when a new entry is fetched, so it also holds the
  // entry being driven for its whole repeat window.
  always_ff @(posedge clock) begin
    if (wr_en && !busy_q) begin
      tbl_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_q <= tbl_mem[rd_addr_d];
    end
  end

  // On an entry's first cycle the downcounter value comes straight from the
  // freshly read rpt field; afterwards from cnt_q.
  always_comb begin
    eff_cnt  = first_q ? rd_q[6 +: RPTW] : cnt_q;
    ent_last = (eff_cnt == '0);
    last_ent = ({1'b0, pc_q} == (len_q - LEN_ONE));
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pc_d      = pc_q;
    cyc_d     = cyc_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    first_d   = 1'b0;
    rd_en     = 1'b0;
    rd_addr_d = pc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // stop beats a simultaneous run
        if (run && !stop) begin
          cyc_d = '0;
          if (len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PRIME;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pc_d    = '0;
            len_d   = (len > DEPTH_L) ? DEPTH_L : len;
          end
        end
      end
      S_PRIME: begin
        if (stop) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else begin
          rd_en     = 1'b1;
          rd_addr_d = pc_q;
          first_d   = 1'b1;
          state_d   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (stop) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else begin
          if (cyc_q != 32'hFFFF_FFFF) begin
            cyc_d = cyc_q + 32'd1;
          end
          if (!ent_last) begin
            cnt_d = eff_cnt - 1'b1;
          end else if (last_ent) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // prefetch next entry in this entry's last cycle: zero bubble
            pc_d      = pc_q + PC_ONE;
            rd_en     = 1'b1;
            rd_addr_d = pc_q + PC_ONE;
            first_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    drv_d = (state_d == S_DRIVE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drv_q   <= 1'b0;
      pc_q    <= '0;
      cyc_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drv_q   <= drv_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Stimulus is the registered table word qualified by the registered DRIVE
  // flag, so b12 sees all zeros outside DRIVE.
  assign obs       = drv_q & rd_q[5];
  assign k         = {4{drv_q}} & rd_q[4:1];
  assign start     = drv_q & rd_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pc        = pc_q;
  assign cyc_count = cyc_q;

endmodule

// File: tb/tb_stim_replay_ctrl.sv
module tb_stim_replay_ctrl;

  localparam int AW = 10;
  localparam int DEPTH = 1024;
  localparam int RPTW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [6+RPTW-1:0] wr_data;
  logic [AW:0]       len;
  logic              run;
  logic              stop;
  logic              busy;
  logic              done;
  logic              obs;
  logic [3:0]        k;
  logic              start;
  logic [AW-1:0]     pc;
  logic [31:0]       cyc_count;

  int tests = 0;
  int failed = 0;

  stim_replay_ctrl #(.AW(AW), .DEPTH(DEPTH), .RPTW(RPTW)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .len(len), .run(run), .stop(stop), .busy(busy),
    .done(done), .obs(obs), .k(k), .start(start), .pc(pc),
    .cyc_count(cyc_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [6+RPTW-1:0] wr_data;
    logic              run;
    logic              stop;
    logic [AW:0]       len;
    logic              exp_busy;
    logic              exp_done;
    logic [5:0]        exp_op;
    logic [AW-1:0]     exp_pc;
    logic [31:0]       exp_cyc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input int wa, input int rpt, input int wop,
                              input logic r, input logic s, input int l,
                              input logic eb, input logic ed, input int eop,
                              input int epc, input int ecyc);
    vec_t v;
    v.wr_en    = w;
    v.wr_addr  = AW'(wa);
    v.wr_data  = {RPTW'(rpt), 6'(wop)};
    v.run      = r;
    v.stop     = s;
    v.len      = (AW+1)'(l);
    v.exp_busy = eb;
    v.exp_done = ed;
    v.exp_op   = 6'(eop);
    v.exp_pc   = AW'(epc);
    v.exp_cyc  = 32'(ecyc);
    return v;
  endfunction

  function automatic logic [5:0] op_now();
    return {obs, k, start};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; run = 1'b0; stop = 1'b0;
  endtask

  task automatic write_entry(input int a, input int rpt, input int op);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = {RPTW'(rpt), 6'(op)};
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_run(input int l);
    run = 1'b1; len = (AW+1)'(l);
    step();
    run = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    int bad;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; run = 1'b0; stop = 1'b0;

    //        w  wa rpt op   run stop len  busy done op   pc cyc
    // basic: three rpt=0 entries
    vecs.push_back(mk(1, 0, 0, 'h21, 0, 0, 0, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 1, 0, 'h04, 0, 0, 0, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 2, 0, 'h3F, 0, 0, 0, 0, 0, 0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 0,    1, 0, 3, 1, 0, 0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 3, 1, 0, 'h21, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 3, 1, 0, 'h04, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 3, 1, 0, 'h3F, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 3, 0, 1, 0,    2, 3));
    // repeat: entry0 rpt=4, entry1 rpt=0
    vecs.push_back(mk(1, 0, 4, 'h03, 0, 0, 2, 0, 1, 0,    2, 3));
    vecs.push_back(mk(1, 1, 0, 'h10, 0, 0, 2, 0, 1, 0,    2, 3));
    vecs.push_back(mk(0, 0, 0, 0,    1, 0, 2, 1, 0, 0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 2, 1, 0, 'h03, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 2, 1, 0, 'h03, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 2, 1, 0, 'h03, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 2, 1, 0, 'h03, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 2, 1, 0, 'h03, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 2, 1, 0, 'h10, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 2, 0, 1, 0,    1, 6));
    // run+stop together in DONE: both ignored
    vecs.push_back(mk(0, 0, 0, 0,    1, 1, 2, 0, 1, 0,    1, 6));
    // len=0 run: straight to DONE, cyc_count cleared
    vecs.push_back(mk(0, 0, 0, 0,    1, 0, 0, 0, 1, 0,    1, 0));

    step(); step();
    reset = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset op", 32'(op_now()), 0);
    chk("reset pc", 32'(pc), 0);
    chk("reset cyc", cyc_count, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      run = vecs[i].run; stop = vecs[i].stop; len = vecs[i].len;
      step();
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d op", i), 32'(op_now()), 32'(vecs[i].exp_op));
      chk($sformatf("vec%0d pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d cyc", i), cyc_count, vecs[i].exp_cyc);
    end
    idle_inputs();

    // abort: four entries with rpt=9, stop while pc=1
    for (int i = 0; i < 4; i++) write_entry(i, 9, i + 1);
    pulse_run(4);
    for (int n = 0; n < 40 && pc != AW'(1); n++) step();
    chk("abort reach pc1", 32'(pc), 1);
    chk("abort op entry1", 32'(op_now()), 'h02);
    pulse_stop();
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort op", 32'(op_now()), 0);
    chk("abort pc held", 32'(pc), 1);

    // restart from pc=0, then write while busy (must be dropped)
    pulse_run(4);
    step();
    chk("restart op", 32'(op_now()), 'h01);
    chk("restart pc", 32'(pc), 0);
    write_entry(0, 0, 'h3A);
    pulse_stop();

    // run+stop together from IDLE: stays idle
    run = 1'b1; stop = 1'b1; len = 4;
    step();
    idle_inputs();
    chk("runstop busy", 32'(busy), 0);
    chk("runstop done", 32'(done), 0);
    step();
    chk("runstop still idle", 32'(busy), 0);

    // re-run confirms dropped write
    pulse_run(4);
    step();
    chk("busy write dropped", 32'(op_now()), 'h01);

    // reset during DRIVE
    step(); step();
    reset = 1'b1;
    step();
    chk("midreset busy", 32'(busy), 0);
    chk("midreset done", 32'(done), 0);
    chk("midreset op", 32'(op_now()), 0);
    chk("midreset pc", 32'(pc), 0);
    chk("midreset cyc", cyc_count, 0);
    reset = 1'b0;
    pulse_run(2);
    chk("postreset prime op", 32'(op_now()), 0);
    step();
    chk("postreset table kept", 32'(op_now()), 'h01);
    pulse_stop();

    // len=0 from IDLE
    pulse_run(0);
    chk("len0 done", 32'(done), 1);
    chk("len0 busy", 32'(busy), 0);
    chk("len0 op", 32'(op_now()), 0);
    chk("len0 cyc", cyc_count, 0);

    // full table, rpt=0, opcode = index low bits
    for (int i = 0; i < DEPTH; i++) write_entry(i, 0, i & 'h3F);
    pulse_run(DEPTH);
    chk("full prime busy", 32'(busy), 1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      if (op_now() != 6'(i & 'h3F) || pc != AW'(i) || !busy) bad++;
    end
    chk("full contiguous errs", 32'(bad), 0);
    step();
    chk("full done", 32'(done), 1);
    chk("full busy", 32'(busy), 0);
    chk("full pc", 32'(pc), DEPTH - 1);
    chk("full cyc", cyc_count, DEPTH);

    // len beyond DEPTH clamps to DEPTH
    pulse_run(2047);
    for (int n = 0; n < 1100 && !done; n++) step();
    chk("clamp done", 32'(done), 1);
    chk("clamp cyc", cyc_count, DEPTH);
    chk("clamp pc", 32'(pc), DEPTH - 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
